mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Word-addressed memory responder that serves the CPU's load/store bus (adr, MemWrite,
//  writedata -> readdata). It holds DEPTH 32-bit words and answers each accepted request
//  after a programmable wait-state count, using a req/ready handshake. It flags misaligned
//  and out-of-range accesses with err. It sits between the multicycle core and on-chip RAM.
// PARAMETERS
//  DEPTH        1024           number of 32-bit words; power of two; ADDR_W = log2(DEPTH)
//  WAIT_CYCLES  2              extra wait states between acceptance and response (0..15)
//  BASE         32'h0000_0000  byte base address of the window; aligned to 4*DEPTH
// PORTS
//  clk    in   1   clock; all state changes on the rising edge
//  rst    in   1   asynchronous, active-low reset
//  req    in   1   request valid; sampled only in IDLE
//  we     in   1   1 = write, 0 = read; captured with req
//  adr    in   32  byte address; captured with req
//  wdata  in   32  write data; captured with req
//  rdata  out  32  read data; valid while ready=1 for a read with err=0
//  ready  out  1   one-cycle response strobe
//  err    out  1   error flag; valid only while ready=1
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ready=0, err=0, rdata=0, wait counter=0,
//   capture regs=0. RAM contents are not reset.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE: if req=1 at an edge, capture we/adr/wdata and load cnt=WAIT_CYCLES.
//   Go to WAIT if WAIT_CYCLES>0, else go to RESP.
//  WAIT: cnt decrements each edge. When cnt reaches 1, the next edge goes to RESP.
//   Exactly WAIT_CYCLES cycles are spent in WAIT.
//  Entry edge into RESP: perform the access.
//   Write: RAM[idx] <= wdata. Read: rdata <= RAM[idx] (registered).
//  RESP: ready=1 for exactly one cycle. Next edge always goes to IDLE.
//  ready falls to 0 on leaving RESP. rdata holds its last value until the next read response.
//  Latency: req sampled at edge k -> ready=1 during the cycle after edge k+1+WAIT_CYCLES.
//   Minimum transaction period is WAIT_CYCLES+2 cycles.
//  Handshake: inputs outside IDLE are ignored. Changes to req/adr/wdata after acceptance
//   have no effect. If req is still 1 in the IDLE cycle after RESP, a new transaction starts.
//   The initiator drops req on seeing ready to avoid a duplicate.
//  Address decode: idx = adr[ADDR_W+1:2]. in_range = (adr - BASE) < 4*DEPTH.
//   misaligned = adr[1:0] != 0. err = misaligned | ~in_range.
//  Error access: no RAM write, rdata <= 0, err=1 together with ready.
//  Address never wraps: adr = BASE+4*DEPTH is out of range (err), not index 0.
//   The last word BASE+4*(DEPTH-1) is valid.
//  Reset mid-transaction (IDLE/WAIT): aborts immediately. A pending write is never
//   committed; only the RESP-entry edge commits.
// TESTING
//  1 Reset: rst=0 mid-run -> ready=0, err=0, rdata=0 immediately (async).
//    Release -> IDLE, no ready pulse.
//  2 WAIT_CYCLES=2: write adr=0x10, wdata=0xDEADBEEF, req sampled at edge 0
//    -> ready=1 after edge 3, err=0.
//    Then read 0x10 -> rdata=0xDEADBEEF, err=0.
//  3 Misaligned write adr=0x13, wdata=0x0 -> ready=1, err=1.
//    Read 0x10 -> still 0xDEADBEEF. Read 0x13 -> rdata=0, err=1.
//  4 Range: write/read adr=0xFFC (DEPTH=1024) -> ok, data returns.
//    adr=0x1000 -> err=1, rdata=0, word 0 unchanged.
//  5 Write 0x20=0x12345678, then write 0x20=0xCAFEF00D with rst=0 pulsed in WAIT
//    -> read 0x20 returns 0x12345678.
//  6 req held at 1 through ready; change adr after acceptance -> first response uses
//    the captured adr, a second transaction starts in the next IDLE cycle.
//    Repeat with WAIT_CYCLES=0 -> ready 2 cycles after acceptance edge.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the core load/store bus: req/ready handshake,
// programmable wait states, and err on misaligned or out-of-window accesses.
module mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W     = 4;
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cap_en_c;

    logic               cap_we;
    logic [31:0]        cap_adr;
    logic [31:0]        cap_wdata;
    logic               err_q;

    logic               acc_en_c;
    logic               acc_we_c;
    logic [31:0]        acc_adr_c;
    logic [31:0]        acc_wdata_c;
    logic [ADDR_W-1:0]  acc_idx_c;
    logic               acc_err_c;

    logic [31:0]        mem [DEPTH];

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cap_en_c  = 1'b1;
                    cnt_nxt   = WAIT_LD;
                    state_nxt = (WAIT_LD != '0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // With zero wait states the access edge is also the capture edge, so take live inputs
    always_comb begin
        acc_en_c    = (state_nxt == S_RESP) && (state != S_RESP);
        acc_we_c    = (state == S_IDLE) ? we    : cap_we;
        acc_adr_c   = (state == S_IDLE) ? adr   : cap_adr;
        acc_wdata_c = (state == S_IDLE) ? wdata : cap_wdata;
        acc_idx_c   = acc_adr_c[ADDR_W+1:2];
        acc_err_c   = (acc_adr_c[1:0] != 2'b00) || ((acc_adr_c - BASE) >= WIN_BYTES);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_adr   <= '0;
            cap_wdata <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cap_en_c) begin
                cap_we    <= we;
                cap_adr   <= adr;
                cap_wdata <= wdata;
            end
            if (acc_en_c) begin
                err_q <= acc_err_c;
                if (acc_err_c) begin
                    rdata <= '0;
                end else if (!acc_we_c) begin
                    rdata <= mem[acc_idx_c];
                end
            end
            ready <= (state == S_RESP);
            err   <= (state == S_RESP) && err_q;
        end
    end

    // RAM array is intentionally not reset; writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (rst && acc_en_c && acc_we_c && !acc_err_c) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

endmodule
